// File: rtl/mem_wb_stage.sv
// MIPS32 memory stage plus MEM/WB pipeline register: wait-stated data memory, branch resolution, stall request.
// Define MEM_STATS_EN to add saturating load/store/stall counters.
module mem_wb_stage #(
  parameter int MEM_WORDS = 64,
  parameter int MEM_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] sumador2_EX_MEM,
  input  logic        Zero_Flag_EX_MEM,
  input  logic [31:0] Resultado_ALU_EX_MEM,
  input  logic [31:0] Read_Data_2_EX_MEM,
  input  logic [4:0]  Instruccion_MUX_EX_MEM,
  input  logic        Branch_EX_MEM,
  input  logic        MemToRead_EX_MEM,
  input  logic        MemToWrite_EX_MEM,
  input  logic        RegWrite_EX_MEM,
  input  logic        MemToReg_EX_MEM,
  output logic        PCSrc,
  output logic [31:0] Branch_Target,
  output logic        Stall,
  output logic [31:0] Read_Data_MEM_WB,
  output logic [31:0] Resultado_ALU_MEM_WB,
  output logic [4:0]  Instruccion_MUX_MEM_WB,
  output logic        RegWrite_MEM_WB,
  output logic        MemToReg_MEM_WB,
  output logic        Misaligned_Err
`ifdef MEM_STATS_EN
  ,
  output logic [15:0] Load_Count,
  output logic [15:0] Store_Count,
  output logic [15:0] Stall_Count
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [2:0] LAT_M1 = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

  typedef enum logic { S_IDLE, S_WAIT } state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] mem_q [MEM_WORDS];

  logic [AW-1:0] idx;
  logic          mem_op, aligned, req, misaligned, stall, complete;
  logic [31:0]   rd_data_d;

  logic [31:0] rd_data_q, alu_q;
  logic [4:0]  dst_q;
  logic        regwrite_q, memtoreg_q, err_q;

  assign idx        = Resultado_ALU_EX_MEM[AW+1:2];
  assign mem_op     = MemToRead_EX_MEM | MemToWrite_EX_MEM;
  assign aligned    = (Resultado_ALU_EX_MEM[1:0] == 2'b00);
  assign req        = mem_op & aligned;
  assign misaligned = mem_op & ~aligned;

  // Stall covers every cycle of an access except its completing one.
  always_comb begin
    stall = 1'b0;
    if (state_q == S_IDLE) stall = req && (MEM_LAT != 0);
    else                   stall = (cnt_q != 3'd0);
  end

  assign complete = req & ~stall;
  assign Stall    = stall;

  assign PCSrc         = Branch_EX_MEM & Zero_Flag_EX_MEM & ~stall & ~reset;
  assign Branch_Target = sumador2_EX_MEM;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req && (MEM_LAT != 0)) begin
            state_q <= S_WAIT;
            cnt_q   <= LAT_M1;
          end
        end
        S_WAIT: begin
          if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
          else               state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write wins when both read and write are requested, so the load path returns zero then.
  always_comb begin
    rd_data_d = 32'd0;
    if (complete && MemToRead_EX_MEM && !MemToWrite_EX_MEM) rd_data_d = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    if (!reset && complete && MemToWrite_EX_MEM) mem_q[idx] <= Read_Data_2_EX_MEM;
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= 32'd0;
      alu_q      <= 32'd0;
      dst_q      <= 5'd0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (misaligned) err_q <= 1'b1;
      if (stall) begin
        regwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        alu_q      <= Resultado_ALU_EX_MEM;
        dst_q      <= Instruccion_MUX_EX_MEM;
        regwrite_q <= RegWrite_EX_MEM & ~misaligned;
        memtoreg_q <= MemToReg_EX_MEM;
      end
    end
  end

  assign Read_Data_MEM_WB       = rd_data_q;
  assign Resultado_ALU_MEM_WB   = alu_q;
  assign Instruccion_MUX_MEM_WB = dst_q;
  assign RegWrite_MEM_WB        = regwrite_q;
  assign MemToReg_MEM_WB        = memtoreg_q;
  assign Misaligned_Err         = err_q;

`ifdef MEM_STATS_EN
  logic [15:0] load_cnt_q, store_cnt_q, stall_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_q  <= 16'd0;
      store_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (complete && MemToWrite_EX_MEM)     store_cnt_q <= sat_inc(store_cnt_q);
      else if (complete && MemToRead_EX_MEM) load_cnt_q  <= sat_inc(load_cnt_q);
      if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign Load_Count  = load_cnt_q;
  assign Store_Count = store_cnt_q;
  assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline register: the memory stage of the MIPS32 pipeline, followed by the MEM/WB pipeline register.
- Takes the EX/MEM outputs and does three jobs:
  - performs data-memory loads and stores against an internal word array, with a configurable wait-state latency;
  - resolves branches;
  - registers the result toward write-back.
- Raises a stall request while a multi-cycle access is in flight.

Parameters:
- MEM_WORDS, 64, data-memory depth in 32-bit words (power of 2, 16..1024).
- MEM_LAT, 2, wait cycles per load/store (0..7); 0 means single-cycle access.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- sumador2_EX_MEM  in  32  branch target address
- Zero_Flag_EX_MEM  in  1  ALU zero flag
- Resultado_ALU_EX_MEM  in  32  ALU result / memory byte address
- Read_Data_2_EX_MEM  in  32  store data
- Instruccion_MUX_EX_MEM  in  5  destination register
- Branch_EX_MEM, MemToRead_EX_MEM, MemToWrite_EX_MEM, RegWrite_EX_MEM, MemToReg_EX_MEM  in  1 each  control bits
- PCSrc  out  1  branch taken
- Branch_Target  out  32  equals sumador2_EX_MEM
- Stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle
- Read_Data_MEM_WB  out  32  load data
- Resultado_ALU_MEM_WB  out  32  registered ALU result
- Instruccion_MUX_MEM_WB  out  5  registered destination register
- RegWrite_MEM_WB, MemToReg_MEM_WB  out  1 each  registered controls
- Misaligned_Err  out  1  sticky misaligned-access flag

Behaviour:
- Reset:
  - All MEM/WB outputs are 0; Misaligned_Err is 0; FSM goes to IDLE; wait counter is 0.
  - Memory contents are not cleared.
  - Reset mid-access abandons the access: no write occurs and Stall drops in the cycle after the reset edge.
- Word index: Resultado_ALU_EX_MEM[log2(MEM_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo MEM_WORDS*4.
- Request: req = (MemToRead_EX_MEM | MemToWrite_EX_MEM) & aligned, where aligned means address[1:0] == 0.
- Branch resolution:
  - PCSrc = Branch_EX_MEM & Zero_Flag_EX_MEM & ~Stall & ~reset (combinational).
  - Branch_Target = sumador2_EX_MEM (combinational).
- FSM states: IDLE, WAIT.
  - IDLE, req=1, MEM_LAT=0: access completes at the next edge; Stall=0.
  - IDLE, req=1, MEM_LAT>0: Stall=1 combinationally; at the next edge go to WAIT and load cnt = MEM_LAT-1.
  - WAIT, cnt != 0: Stall=1; cnt decrements each edge.
  - WAIT, cnt == 0: Stall=0; access completes at this edge; return to IDLE.
  - A load/store presented in cycle N produces exactly MEM_LAT stall cycles. Its result appears on MEM/WB after edge N+MEM_LAT+1.
- Access completion edge:
  - Store: mem[idx] <= Read_Data_2_EX_MEM.
  - Load: Read_Data_MEM_WB <= mem[idx].
  - If MemToRead and MemToWrite are both 1, the write wins and Read_Data_MEM_WB <= 0.
  - MEM/WB control and data fields are loaded from EX/MEM.
- Non-memory instruction (neither MemToRead nor MemToWrite): MEM/WB loads every edge; Read_Data_MEM_WB <= 0; no stall.
- Stall cycles: MEM/WB loads a bubble (RegWrite_MEM_WB=0, MemToReg_MEM_WB=0, other fields hold). EX/MEM inputs are required to stay stable while Stall=1; the stage does not sample them mid-wait.
- Misaligned access (MemToRead or MemToWrite set and address[1:0] != 0):
  - No memory access and no stall.
  - MEM/WB loads with RegWrite_MEM_WB=0.
  - Misaligned_Err is set and stays set until reset.
- Load followed immediately by a store to the same word: the store is performed in its own completion cycle. There is no hazard inside the block.

Optional Feature:
- MEM_STATS_EN defined: adds outputs Load_Count[15:0], Store_Count[15:0] and Stall_Count[15:0].
  - Load_Count and Store_Count increment once per completed access.
  - Stall_Count increments every cycle Stall=1.
  - All three saturate at 16'hFFFF and clear on reset.
- MEM_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- MEM_LAT=2, store addr 0x10 data 0xDEADBEEF, then load addr 0x10 with RegWrite=1, dest=5 -> Stall high for exactly 2 cycles per access; load gives Read_Data_MEM_WB=0xDEADBEEF, Instruccion_MUX_MEM_WB=5, RegWrite_MEM_WB=1 three edges after presentation.
- MEM_LAT=0, back-to-back stores to 0x0 and 0x4, then loads from both -> Stall never asserted; data returns one edge after each load.
- Branch=1, Zero=1, sumador2=0x00400020, no memory op -> PCSrc=1, Branch_Target=0x00400020; with Zero=0 -> PCSrc=0.
- Load addr 0x102 -> Misaligned_Err=1, RegWrite_MEM_WB=0, Stall=0, memory unchanged; flag stays 1 until reset.
- MEM_WORDS=64, store 0xA5A5A5A5 to 0x100 then load 0x000 -> 0xA5A5A5A5 (wrap).
- Reset asserted during the second stall cycle of a store -> no write to target word, Stall=0 after the reset edge, all MEM/WB outputs 0.
